// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction format, opcodes and fetch FSM encoding.
package cpu_pkg;

   localparam int INSTR_W = 16;

   // Instruction fields: opcode [15:12], A [11:8], B [7:4], C [3:0]
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int FA_MSB  = 11;
   localparam int FA_LSB  = 8;
   localparam int FB_MSB  = 7;
   localparam int FB_LSB  = 4;
   localparam int FC_MSB  = 3;
   localparam int FC_LSB  = 0;

   localparam logic [3:0] OPC_HALT = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_LOAD = 2'd2,
      ST_HALT = 2'd3
   } fetch_state_e;

   function automatic logic [3:0] opcode(input logic [INSTR_W-1:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/ifetch_pc_reg.sv
// Program counter with load / increment (wrapping) and the latched redirect
// target that is held while a memory request is outstanding.
module ifetch_pc_reg #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              inc,
   input  logic              pend_set,
   input  logic [ADDR_W-1:0] pend_addr,
   input  logic              pend_clr,
   output logic [ADDR_W-1:0] pc,
   output logic              redirect_pend,
   output logic [ADDR_W-1:0] pend_target
);

   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (rst) begin
         pc            <= RESET_PC;
         redirect_pend <= 1'b0;
         pend_target   <= '0;
      end else begin
         if (load)
            pc <= load_addr;
         else if (inc)
            pc <= pc + ONE;

         // clear wins: a redirect arriving on the ack cycle is consumed directly
         if (pend_clr)
            redirect_pend <= 1'b0;
         else if (pend_set) begin
            redirect_pend <= 1'b1;
            pend_target   <= pend_addr;
         end
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads imem at PC and strobes the word into the IR.
// Optional request watchdog enabled by defining IFETCH_TIMEOUT_EN.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int                ADDR_W         = 8,
   parameter logic [ADDR_W-1:0] RESET_PC       = '0,
   parameter int                TIMEOUT_CYCLES = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fetch_en,
   input  logic               pc_load,
   input  logic [ADDR_W-1:0]  pc_target,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] ir_din,
   output logic               ir_write_en,
   output logic [ADDR_W-1:0]  pc,
   output logic               busy,
   output logic               halted,
   output logic               fetch_err
);

   fetch_state_e      state, state_n;
   logic              pc_ld, pc_inc, pend_set, pend_clr, capture;
   logic [ADDR_W-1:0] pc_ld_addr;
   logic              redirect_pend;
   logic [ADDR_W-1:0] pend_target;
   logic              timeout_hit;

   ifetch_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk           (clk),
      .rst           (rst),
      .load          (pc_ld),
      .load_addr     (pc_ld_addr),
      .inc           (pc_inc),
      .pend_set      (pend_set),
      .pend_addr     (pc_target),
      .pend_clr      (pend_clr),
      .pc            (pc),
      .redirect_pend (redirect_pend),
      .pend_target   (pend_target)
   );

`ifdef IFETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wd_cnt;

   // counts completed REQ cycles; expires on the last allowed cycle without ack
   assign timeout_hit = (state == ST_REQ) && !imem_ack &&
                        (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt    <= '0;
         fetch_err <= 1'b0;
      end else begin
         wd_cnt    <= (state == ST_REQ) ? wd_cnt + 1'b1 : '0;
         fetch_err <= fetch_err | timeout_hit;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign fetch_err   = 1'b0;
`endif

   always_comb begin
      state_n    = state;
      pc_ld      = 1'b0;
      pc_ld_addr = pc_target;
      pc_inc     = 1'b0;
      pend_set   = 1'b0;
      pend_clr   = 1'b0;
      capture    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pc_load)
               pc_ld = 1'b1;
            else if (fetch_en)
               state_n = ST_REQ;
         end
         ST_REQ: begin
            pend_set = pc_load;
            if (imem_ack) begin
               // a redirect seen during the request makes the returned word stale
               if (redirect_pend || pc_load) begin
                  pc_ld      = 1'b1;
                  pc_ld_addr = pc_load ? pc_target : pend_target;
                  pend_clr   = 1'b1;
                  state_n    = ST_IDLE;
               end else begin
                  capture = 1'b1;
                  state_n = ST_LOAD;
               end
            end else if (timeout_hit) begin
               pend_clr = 1'b1;
               state_n  = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (opcode(ir_din) == OPC_HALT)
               state_n = ST_HALT;
            else begin
               state_n = ST_IDLE;
               pc_ld   = pc_load;
               pc_inc  = !pc_load;
            end
         end
         ST_HALT: state_n = ST_HALT;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         ir_din      <= '0;
         ir_write_en <= 1'b0;
         imem_req    <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state       <= state_n;
         if (capture)
            ir_din <= imem_rdata;
         ir_write_en <= (state_n == ST_LOAD);
         imem_req    <= (state_n == ST_REQ);
         halted      <= (state_n == ST_HALT);
      end
   end

   assign imem_addr = pc;
   assign busy      = (state == ST_REQ) || (state == ST_LOAD);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table, directed corner cases and
// a randomized run against a transaction-level reference model.
module tb_instr_fetch;

   logic        clk, rst, fetch_en, pc_load;
   logic [7:0]  pc_target;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] ir_din;
   logic        ir_write_en;
   logic [7:0]  pc;
   logic        busy, halted, fetch_err;

   int checks = 0;
   int errors = 0;

   instr_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_en    (fetch_en),
      .pc_load     (pc_load),
      .pc_target   (pc_target),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .ir_din      (ir_din),
      .ir_write_en (ir_write_en),
      .pc          (pc),
      .busy        (busy),
      .halted      (halted),
      .fetch_err   (fetch_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0]  start;
      int          wt;
      logic [15:0] word;
      logic [7:0]  exp_pc;
      logic [15:0] exp_ir;
      logic        exp_halt;
   } vec_t;

   vec_t vt [5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; fetch_en = 1'b0; pc_load = 1'b0; imem_ack = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic redirect(input logic [7:0] t);
      pc_load = 1'b1; pc_target = t;
      @(negedge clk);
      pc_load = 1'b0;
   endtask

   // One fetch request; memory acks after wt wait states. Optional redirect
   // pulsed in the first REQ cycle. Window is bounded so a stuck DUT cannot hang.
   task automatic run_fetch(input int wt, input logic [15:0] w, input bit redir,
                            input logic [7:0] tgt, input logic [7:0] ea,
                            output int nreq, output int nstrb, output int lat,
                            output int bad);
      nreq = 0; nstrb = 0; lat = -1; bad = 0;
      fetch_en = 1'b1;
      @(negedge clk);
      fetch_en = 1'b0;
      for (int c = 0; c < wt + 6; c++) begin
         if (imem_req) begin
            nreq++;
            if (imem_addr !== ea || busy !== 1'b1) bad++;
         end
         if (ir_write_en) begin
            nstrb++;
            if (lat < 0) lat = c;
         end
         if (redir && c == 0) begin pc_load = 1'b1; pc_target = tgt; end
         if (imem_req && c == wt) begin imem_ack = 1'b1; imem_rdata = w; end
         @(negedge clk);
         pc_load = 1'b0; imem_ack = 1'b0; imem_rdata = 16'($urandom);
      end
   endtask

   initial begin
      int nreq, nstrb, lat, bad, op, wt, n;
      logic [7:0]  m_pc, t;
      logic [15:0] m_ir, w;
      bit          m_halt;

      rst = 1'b1; fetch_en = 1'b0; pc_load = 1'b0; pc_target = '0;
      imem_ack = 1'b0; imem_rdata = '0;
      @(negedge clk);
      do_reset();

      chk("rst_pc", pc, 8'h00);
      chk("rst_req", imem_req, 1'b0);
      chk("rst_strobe", ir_write_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_err", fetch_err, 1'b0);
      chk("rst_ir", ir_din, 16'h0000);

      // start, wait states, word, expected pc, expected ir, expected halted
      vt[0] = '{8'h00, 0, 16'h1234, 8'h01, 16'h1234, 1'b0};
      vt[1] = '{8'h10, 4, 16'hABCD, 8'h11, 16'hABCD, 1'b0};
      vt[2] = '{8'hFF, 0, 16'h0001, 8'h00, 16'h0001, 1'b0};
      vt[3] = '{8'h7F, 1, 16'hEFFF, 8'h80, 16'hEFFF, 1'b0};
      vt[4] = '{8'h05, 2, 16'hF000, 8'h05, 16'hF000, 1'b1};

      for (int i = 0; i < 5; i++) begin
         do_reset();
         redirect(vt[i].start);
         chk($sformatf("v%0d_start_pc", i), pc, vt[i].start);
         run_fetch(vt[i].wt, vt[i].word, 1'b0, 8'h00, vt[i].start, nreq, nstrb, lat, bad);
         chk($sformatf("v%0d_req_cycles", i), nreq, vt[i].wt + 1);
         chk($sformatf("v%0d_addr_busy", i), bad, 0);
         chk($sformatf("v%0d_strobes", i), nstrb, 1);
         chk($sformatf("v%0d_strobe_lat", i), lat, vt[i].wt + 1);
         chk($sformatf("v%0d_pc", i), pc, vt[i].exp_pc);
         chk($sformatf("v%0d_ir", i), ir_din, vt[i].exp_ir);
         chk($sformatf("v%0d_halted", i), halted, vt[i].exp_halt);
      end

      // after HALT, requests and redirects are ignored
      run_fetch(0, 16'h1111, 1'b0, 8'h00, 8'h05, nreq, nstrb, lat, bad);
      chk("halt_no_req", nreq, 0);
      chk("halt_no_strobe", nstrb, 0);
      redirect(8'h33);
      chk("halt_pc_hold", pc, 8'h05);

      // redirect during a delayed request: data discarded, next fetch at target
      do_reset();
      redirect(8'h10);
      run_fetch(3, 16'h5555, 1'b1, 8'h40, 8'h10, nreq, nstrb, lat, bad);
      chk("redir_strobes", nstrb, 0);
      chk("redir_pc", pc, 8'h40);
      chk("redir_ir_hold", ir_din, 16'h0000);
      run_fetch(0, 16'h2222, 1'b0, 8'h00, 8'h40, nreq, nstrb, lat, bad);
      chk("redir_next_addr", bad, 0);
      chk("redir_next_pc", pc, 8'h41);
      chk("redir_next_ir", ir_din, 16'h2222);

      // reset in the middle of REQ; the late ack must be ignored
      do_reset();
      redirect(8'h40);
      fetch_en = 1'b1;
      @(negedge clk);
      fetch_en = 1'b0;
      chk("mid_req_on", imem_req, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_req_off", imem_req, 1'b0);
      chk("mid_pc", pc, 8'h00);
      chk("mid_busy", busy, 1'b0);
      imem_ack = 1'b1; imem_rdata = 16'h9999;
      @(negedge clk);
      imem_ack = 1'b0;
      n = 0;
      for (int c = 0; c < 3; c++) begin
         if (ir_write_en) n++;
         @(negedge clk);
      end
      chk("mid_no_strobe", n, 0);
      chk("mid_ir", ir_din, 16'h0000);

      // long stall: watchdog fires after 15 cycles if built in, else REQ waits
      do_reset();
      redirect(8'h22);
`ifdef IFETCH_TIMEOUT_EN
      run_fetch(30, 16'h7777, 1'b0, 8'h00, 8'h22, nreq, nstrb, lat, bad);
      chk("to_req_cycles", nreq, 15);
      chk("to_err", fetch_err, 1'b1);
      chk("to_busy", busy, 1'b0);
      chk("to_strobes", nstrb, 0);
      chk("to_pc", pc, 8'h22);
`else
      run_fetch(20, 16'h7777, 1'b0, 8'h00, 8'h22, nreq, nstrb, lat, bad);
      chk("stall_req_cycles", nreq, 21);
      chk("stall_err", fetch_err, 1'b0);
      chk("stall_pc", pc, 8'h23);
`endif

      // randomized operations against a transaction-level model
      do_reset();
      m_pc = 8'h00; m_ir = 16'h0000; m_halt = 1'b0;
      for (int it = 0; it < 60; it++) begin
         if (m_halt && $urandom_range(0, 2) == 0) begin
            do_reset();
            m_pc = 8'h00; m_ir = 16'h0000; m_halt = 1'b0;
         end
         op = $urandom_range(0, 9);
         wt = $urandom_range(1, 3);
         t  = 8'($urandom);
         w  = 16'($urandom);
         if (w[15:12] == 4'hF && $urandom_range(0, 5) != 0) w[15:12] = 4'h3;
         if (op < 2) begin
            redirect(t);
            if (!m_halt) m_pc = t;
         end else if (op < 4) begin
            run_fetch(wt, w, 1'b1, t, m_pc, nreq, nstrb, lat, bad);
            chk("rnd_redir_req", nreq, m_halt ? 0 : wt + 1);
            chk("rnd_redir_strobe", nstrb, 0);
            if (!m_halt) m_pc = t;
         end else begin
            if ($urandom_range(0, 1) == 0) wt = 0;
            run_fetch(wt, w, 1'b0, 8'h00, m_pc, nreq, nstrb, lat, bad);
            chk("rnd_req", nreq, m_halt ? 0 : wt + 1);
            chk("rnd_strobe", nstrb, m_halt ? 0 : 1);
            if (!m_halt) begin
               m_ir = w;
               if (w[15:12] == 4'hF) m_halt = 1'b1;
               else m_pc = m_pc + 8'd1;
            end
         end
         chk("rnd_addr", bad, 0);
         chk("rnd_pc", pc, m_pc);
         chk("rnd_ir", ir_din, m_ir);
         chk("rnd_halted", halted, m_halt);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
